alu_pipe: RTL and testbench

- Parametrised, two-stage pipelined successor to the single-cycle 16-bit datapath ALU.
- Operand width, sub-word lane width and shift-immediate width are generic.
- Operations use a valid/ready handshake with back-pressure and a synchronous flush.
- The N/Z/V flag register sits inside the block and commits only when a result is accepted downstream; it serves as the execute unit of the pipelined core.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_pipe_exec.sv | 115 +++++++++++
 rtl/alu_pipe.sv | 119 +++++++++++
 tb/tb_alu_pipe.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, flag indices and the shared
// saturating-add helper for the pipelined ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_RED    = 4'd2;
  localparam logic [3:0] OP_XOR    = 4'd3;
  localparam logic [3:0] OP_SLL    = 4'd4;
  localparam logic [3:0] OP_SRA    = 4'd5;
  localparam logic [3:0] OP_ROR    = 4'd6;
  localparam logic [3:0] OP_PADDSB = 4'd7;
  localparam int OP_MEM_MSB = 3;

  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 0;

  // Returns {saturated w-bit sum, overflow}.
  // cin=1 with b pre-inverted gives a-b.
  // Saturation direction follows the sign of a.
  function automatic logic [64:0] sat_add(
    input logic [63:0] a,
    input logic [63:0] b,
    input int          w,
    input logic        cin = 1'b0
  );
    logic [63:0] m;
    logic [63:0] s;
    logic        sa;
    logic        ov;
    m  = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    s  = (a + b + {63'd0, cin}) & m;
    sa = a[w-1];
    ov = (sa == b[w-1]) && (s[w-1] != sa);
    if (ov) s = sa ? (64'd1 << (w - 1)) : (m >> 1);
    return {s, ov};
  endfunction

endpackage

// File: rtl/alu_pipe_exec.sv
// alu_pipe_exec: combinational compute for the
// second pipeline stage (result, flags, flag_wr).
module alu_pipe_exec
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int LANE_W = 4,
  parameter int IMM_W  = 4
) (
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [IMM_W-1:0] i_imm,
  output logic [WIDTH-1:0] o_res,
  output logic [2:0]       o_flags,
  output logic             o_fwr,
  output logic             o_vwr
);

  localparam int SH_W = $clog2(WIDTH);

  logic [SH_W-1:0]    w_sh;
  logic [64:0]        w_add;
  logic [64:0]        w_sub;
  logic [64:0]        w_lane;
  logic [WIDTH-1:0]   w_pad;
  logic [WIDTH-1:0]   w_red;
  logic [WIDTH-1:0]   w_sll;
  logic [WIDTH-1:0]   w_sra;
  logic [2*WIDTH-1:0] w_rr;
  logic [WIDTH-1:0]   w_mem;
  logic               w_v;

  assign w_sh  = i_imm[SH_W-1:0];
  assign w_add = sat_add(64'(i_a), 64'(i_b),
                         WIDTH);
  assign w_sub = sat_add(64'(i_a), 64'(~i_b),
                         WIDTH, 1'b1);
  assign w_sll = i_a << w_sh;
  assign w_sra = $signed(i_a) >>> w_sh;
  assign w_rr  = {i_a, i_a} >> w_sh;
  assign w_mem = i_a
               + (WIDTH'($signed(i_imm)) << 1);

  // Lane-wise saturating add, no cross-lane carry.
  always_comb begin
    w_pad  = '0;
    w_lane = '0;
    for (int i = 0; i < WIDTH / LANE_W; i++) begin
      w_lane = sat_add(
        64'(i_a[i*LANE_W +: LANE_W]),
        64'(i_b[i*LANE_W +: LANE_W]),
        LANE_W);
      w_pad[i*LANE_W +: LANE_W] =
        w_lane[LANE_W:1];
    end
  end

  // Wrapping sum of every signed byte of A and B.
  always_comb begin
    w_red = '0;
    for (int i = 0; i < WIDTH / 8; i++) begin
      w_red = w_red
            + WIDTH'($signed(i_a[i*8 +: 8]))
            + WIDTH'($signed(i_b[i*8 +: 8]));
    end
  end

  // Opcode select plus flag generation.
  always_comb begin
    o_res = '0;
    w_v   = 1'b0;
    o_fwr = 1'b0;
    o_vwr = 1'b0;
    unique case (1'b1)
      i_op[OP_MEM_MSB]: o_res = w_mem;
      (i_op == OP_ADD): begin
        o_res = w_add[WIDTH:1];
        w_v   = w_add[0];
        o_fwr = 1'b1;
        o_vwr = 1'b1;
      end
      (i_op == OP_SUB): begin
        o_res = w_sub[WIDTH:1];
        w_v   = w_sub[0];
        o_fwr = 1'b1;
        o_vwr = 1'b1;
      end
      (i_op == OP_RED): o_res = w_red;
      (i_op == OP_XOR): begin
        o_res = i_a ^ i_b;
        o_fwr = 1'b1;
      end
      (i_op == OP_SLL): begin
        o_res = w_sll;
        o_fwr = 1'b1;
      end
      (i_op == OP_SRA): begin
        o_res = w_sra;
        o_fwr = 1'b1;
      end
      (i_op == OP_ROR): begin
        o_res = w_rr[WIDTH-1:0];
        o_fwr = 1'b1;
      end
      (i_op == OP_PADDSB): o_res = w_pad;
      default: o_res = '0;
    endcase
    o_flags         = '0;
    o_flags[FLAG_N] = o_res[WIDTH-1];
    o_flags[FLAG_Z] = (o_res == '0);
    o_flags[FLAG_V] = w_v;
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready ALU with flush
// and a committed N/Z/V flag register.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int LANE_W = 4,
  parameter int IMM_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [IMM_W-1:0] imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       out_flags,
  output logic             flag_wr,
  output logic [2:0]       flags
);

  logic             r_s1_v;
  logic [3:0]       r_s1_op;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [IMM_W-1:0] r_s1_imm;
  logic             r_s2_v;
  logic [WIDTH-1:0] r_res;
  logic [2:0]       r_oflags;
  logic             r_fwr;
  logic             r_vwr;
  logic [2:0]       r_flags;

  logic             w_s1_rdy;
  logic             w_s2_rdy;
  logic [WIDTH-1:0] w_res;
  logic [2:0]       w_flags;
  logic             w_fwr;
  logic             w_vwr;
  logic             w_commit;

  assign w_s2_rdy  = ~r_s2_v | out_ready;
  assign w_s1_rdy  = ~r_s1_v | w_s2_rdy;
  assign in_ready  = w_s1_rdy;
  assign out_valid = r_s2_v;
  assign result    = r_res;
  assign out_flags = r_oflags;
  assign flag_wr   = r_fwr;
  assign flags     = r_flags;
  assign w_commit  = r_s2_v & out_ready & r_fwr;

  alu_pipe_exec #(
    .WIDTH  (WIDTH),
    .LANE_W (LANE_W),
    .IMM_W  (IMM_W)
  ) u_exec (
    .i_op    (r_s1_op),
    .i_a     (r_s1_a),
    .i_b     (r_s1_b),
    .i_imm   (r_s1_imm),
    .o_res   (w_res),
    .o_flags (w_flags),
    .o_fwr   (w_fwr),
    .o_vwr   (w_vwr)
  );

  // Stage advance, flush kill and flag commit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_v   <= 1'b0;
      r_s1_op  <= '0;
      r_s1_a   <= '0;
      r_s1_b   <= '0;
      r_s1_imm <= '0;
      r_s2_v   <= 1'b0;
      r_res    <= '0;
      r_oflags <= '0;
      r_fwr    <= 1'b0;
      r_vwr    <= 1'b0;
      r_flags  <= '0;
    end else begin
      if (w_commit) begin
        r_flags[FLAG_N] <= r_oflags[FLAG_N];
        r_flags[FLAG_Z] <= r_oflags[FLAG_Z];
        if (r_vwr)
          r_flags[FLAG_V] <= r_oflags[FLAG_V];
      end
      if (flush) begin
        r_s1_v <= 1'b0;
        r_s2_v <= 1'b0;
      end else begin
        if (w_s2_rdy) begin
          r_s2_v <= r_s1_v;
          if (r_s1_v) begin
            r_res    <= w_res;
            r_oflags <= w_flags;
            r_fwr    <= w_fwr;
            r_vwr    <= w_vwr;
          end
        end
        if (w_s1_rdy) begin
          r_s1_v <= in_valid;
          if (in_valid) begin
            r_s1_op  <= opcode;
            r_s1_a   <= src_a;
            r_s1_b   <= src_b;
            r_s1_imm <= imm;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed scoreboard bench for the
// pipelined ALU with an independent integer model.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic [15:0] src_a;
  logic [15:0] src_b;
  logic [3:0]  imm;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [2:0]  out_flags;
  logic        flag_wr;
  logic [2:0]  flags;

  always #5 clk = ~clk;

  alu_pipe #(
    .WIDTH  (16),
    .LANE_W (4),
    .IMM_W  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .src_a     (src_a),
    .src_b     (src_b),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .out_flags (out_flags),
    .flag_wr   (flag_wr),
    .flags     (flags)
  );

  typedef struct {
    logic [15:0] res;
    logic [2:0]  fl;
    logic        fwr;
    logic        vwr;
  } exp_t;

  exp_t        q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  int          n_out  = 0;
  logic [2:0]  mflags = 3'b000;
  bit          fl_chk = 1'b0;
  bit          acc;
  logic [15:0] last_res;
  logic [2:0]  last_fl;
  logic        last_fwr;

  function automatic int clampi(int v, int lo,
                                int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic exp_t model(
    logic [3:0] op, logic [15:0] a,
    logic [15:0] b, logic [3:0] im);
    exp_t e;
    int sa = $signed(a);
    int sb = $signed(b);
    int s;
    int ls;
    logic [15:0] r = 16'h0;
    logic ov = 1'b0;
    e.fwr = 1'b0;
    e.vwr = 1'b0;
    if (op >= 4'd8) begin
      r = 16'(int'(a) + 2 * int'($signed(im)));
    end else begin
      case (op)
        4'd0, 4'd1: begin
          s  = (op == 4'd0) ? sa + sb : sa - sb;
          ov = (s > 32767) || (s < -32768);
          r  = 16'(clampi(s, -32768, 32767));
          e.fwr = 1'b1;
          e.vwr = 1'b1;
        end
        4'd2: begin
          s = int'($signed(a[15:8]))
            + int'($signed(a[7:0]))
            + int'($signed(b[15:8]))
            + int'($signed(b[7:0]));
          r = 16'(s);
        end
        4'd3: begin r = a ^ b; e.fwr = 1'b1; end
        4'd4: begin r = a << im; e.fwr = 1'b1; end
        4'd5: begin
          r = 16'($signed(a) >>> im);
          e.fwr = 1'b1;
        end
        4'd6: begin
          r = a;
          repeat (int'(im)) r = {r[0], r[15:1]};
          e.fwr = 1'b1;
        end
        default: begin
          for (int i = 0; i < 4; i++) begin
            ls = int'($signed(a[i*4 +: 4]))
               + int'($signed(b[i*4 +: 4]));
            r[i*4 +: 4] = 4'(clampi(ls, -8, 7));
          end
        end
      endcase
    end
    e.res = r;
    e.fl  = {r[15], (r == 16'h0), ov};
    return e;
  endfunction

  task automatic chk(string tag,
                     logic [31:0] obs,
                     logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(logic v, logic [3:0] op,
                       logic [15:0] a,
                       logic [15:0] b,
                       logic [3:0] im);
    in_valid = v;
    opcode   = op;
    src_a    = a;
    src_b    = b;
    imm      = im;
  endtask

  task automatic step();
    exp_t e;
    bit   ohs;
    #1;
    if (fl_chk)
      chk("flags", 32'(flags), 32'(mflags));
    acc = in_valid && in_ready && !flush
          && rst_n;
    ohs = out_valid && out_ready && rst_n;
    if (acc)
      q.push_back(model(opcode, src_a,
                        src_b, imm));
    if (ohs) begin
      if (q.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        e = q.pop_front();
        chk("result", 32'(result), 32'(e.res));
        chk("out_flags", 32'(out_flags),
            32'(e.fl));
        chk("flag_wr", 32'(flag_wr), 32'(e.fwr));
        last_res = result;
        last_fl  = out_flags;
        last_fwr = flag_wr;
        n_out++;
        if (e.fwr) begin
          mflags[2] = e.fl[2];
          mflags[1] = e.fl[1];
          if (e.vwr) mflags[0] = e.fl[0];
        end
      end
    end
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      mflags = 3'b000;
    end else if (flush) begin
      q.delete();
    end
    #1;
  endtask

  task automatic drain(int budget);
    int n = 0;
    in_valid = 1'b0;
    while (q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk("drain_timeout", q.size(), 0);
  endtask

  task automatic one(logic [3:0] op,
                     logic [15:0] a,
                     logic [15:0] b,
                     logic [3:0] im);
    drive(1'b1, op, a, b, im);
    step();
    in_valid = 1'b0;
    drain(20);
  endtask

  logic [3:0]  bp_op[4];
  logic [15:0] bp_a[4];
  logic [15:0] bp_b[4];
  logic [15:0] held;
  logic [2:0]  fl_before;
  int          idx;
  int          n_acc;
  int          o0;

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 4'd0, 16'h0, 16'h0, 4'h0);
    step();
    step();
    fl_chk = 1'b1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_out_flags", 32'(out_flags), 0);
    chk("rst_flag_wr", 32'(flag_wr), 0);
    chk("rst_flags", 32'(flags), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    rst_n = 1'b1;
    step();

    drive(1'b1, 4'd0, 16'h7FFF, 16'h0001, 4'h0);
    step();
    in_valid = 1'b0;
    chk("lat_first", 32'(out_valid), 0);
    step();
    chk("lat_second", 32'(out_valid), 1);
    step();
    chk("add_res", 32'(last_res), 32'h7FFF);
    chk("add_oflags", 32'(last_fl), 32'b001);
    chk("add_flags", 32'(flags), 32'b001);

    one(4'd1, 16'h8000, 16'h0001, 4'h0);
    chk("sub_res", 32'(last_res), 32'h8000);
    chk("sub_oflags", 32'(last_fl), 32'b101);
    one(4'd3, 16'h00FF, 16'h00FF, 4'h0);
    chk("xor_res", 32'(last_res), 0);
    chk("xor_oflags", 32'(last_fl), 32'b010);
    chk("xor_flags", 32'(flags), 32'b011);

    one(4'd7, 16'h7181, 16'h1181, 4'h0);
    chk("paddsb_res", 32'(last_res), 32'h7282);
    chk("paddsb_fwr", 32'(last_fwr), 0);
    chk("paddsb_flags", 32'(flags), 32'b011);

    one(4'd1, 16'h7FFF, 16'hFFFF, 4'h0);
    chk("subsat_res", 32'(last_res), 32'h7FFF);
    one(4'd1, 16'h0000, 16'h8000, 4'h0);
    chk("subsat_neg", 32'(last_res), 32'h7FFF);
    one(4'd0, 16'h8000, 16'hFFFF, 4'h0);
    chk("addsat_neg", 32'(last_res), 32'h8000);
    one(4'd2, 16'h8080, 16'h7F01, 4'h0);
    chk("red_res", 32'(last_res), 32'hFF80);
    one(4'd6, 16'h1234, 16'h0000, 4'h0);
    chk("ror0_res", 32'(last_res), 32'h1234);
    one(4'd6, 16'h0001, 16'h0000, 4'h4);
    chk("ror4_res", 32'(last_res), 32'h1000);
    one(4'd5, 16'h8000, 16'h0000, 4'hF);
    chk("sra15_res", 32'(last_res), 32'hFFFF);
    one(4'd4, 16'h8001, 16'h0000, 4'h1);
    chk("sll1_res", 32'(last_res), 32'h0002);
    chk("sll1_flags", 32'(flags), 32'b001);

    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 4'(i), 16'($urandom),
            16'($urandom), 4'($urandom));
      step();
      chk("tput_accept", 32'(acc), 1);
    end
    drain(20);

    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bp_op[i] = 4'($urandom_range(0, 15));
      bp_a[i]  = 16'($urandom);
      bp_b[i]  = 16'($urandom);
    end
    idx   = 0;
    n_acc = 0;
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, bp_op[idx], bp_a[idx],
            bp_b[idx], 4'h3);
      step();
      if (acc) begin
        idx++;
        n_acc++;
      end
      if (c == 1) held = result;
    end
    chk("bp_accepts", n_acc, 2);
    chk("bp_in_ready", 32'(in_ready), 0);
    chk("bp_hold", 32'(result), 32'(held));
    chk("bp_out_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    o0 = n_out;
    for (int c = 0; c < 4; c++) begin
      if (idx < 4)
        drive(1'b1, bp_op[idx], bp_a[idx],
              bp_b[idx], 4'h3);
      else
        in_valid = 1'b0;
      step();
      if (acc) idx++;
    end
    chk("bp_consecutive", n_out - o0, 4);
    drain(10);

    out_ready = 1'b0;
    drive(1'b1, 4'd0, 16'h7FFF, 16'h7FFF, 4'h0);
    step();
    drive(1'b1, 4'd0, 16'h0001, 16'h0002, 4'h0);
    step();
    chk("fl_inflight", 32'(out_valid), 1);
    fl_before = flags;
    in_valid  = 1'b0;
    flush     = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_out_valid", 32'(out_valid), 0);
    chk("fl_flags", 32'(flags), 32'(fl_before));
    out_ready = 1'b1;
    step();
    chk("fl_empty", 32'(out_valid), 0);
    one(4'd0, 16'h0005, 16'h0006, 4'h0);
    chk("fl_next_res", 32'(last_res), 32'h000B);

    drive(1'b1, 4'd1, 16'h8000, 16'h0001, 4'h0);
    step();
    in_valid = 1'b0;
    step();
    drive(1'b1, 4'd3, 16'h0F0F, 16'h0000, 4'h0);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flhs_flags", 32'(flags), 32'b101);
    chk("flhs_out_valid", 32'(out_valid), 0);
    step();
    chk("flhs_discard", 32'(out_valid), 0);

    one(4'h8, 16'h0010, 16'h0000, 4'hF);
    chk("mem_res", 32'(last_res), 32'h000E);
    chk("mem_fwr", 32'(last_fwr), 0);
    one(4'hB, 16'hFFFF, 16'h1234, 4'h7);
    chk("mem_wrap", 32'(last_res), 32'h000D);

    out_ready = 1'b0;
    drive(1'b1, 4'd0, 16'h1111, 16'h2222, 4'h0);
    step();
    drive(1'b1, 4'd3, 16'hF0F0, 16'h0000, 4'h0);
    step();
    rst_n = 1'b0;
    flush = 1'b1;
    step();
    rst_n    = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("mrst_out_valid", 32'(out_valid), 0);
    chk("mrst_result", 32'(result), 0);
    chk("mrst_out_flags", 32'(out_flags), 0);
    chk("mrst_flag_wr", 32'(flag_wr), 0);
    chk("mrst_flags", 32'(flags), 0);
    chk("mrst_in_ready", 32'(in_ready), 1);
    out_ready = 1'b1;
    one(4'd3, 16'hA5A5, 16'h0000, 4'h0);
    chk("mrst_next", 32'(last_res), 32'hA5A5);
    chk("mrst_next_flags", 32'(flags), 32'b100);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
